// File: rtl/pcm_pwm_out.sv
// pcm_pwm_out: PCM sample FIFO feeding an edge-aligned PWM / first-order PDM amplifier output.
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   din_i, din_valid_i       PCM sample and its valid; accepted when din_ready_o=1
//   din_ready_o              FIFO not full (combinational)
//   mode_i                   0: PWM, 1: PDM; taken at period boundaries only
//   enable_i                 1: play, 0: idle with amplifier shut down
//   amp_pwm_o, amp_sd_o      modulated output, amplifier enable (both registered)
//   done_o                   one-cycle pulse after a sample is popped
//   underrun_o               sticky flag: boundary reached with the FIFO empty
//   fifo_level_o             FIFO occupancy
module pcm_pwm_out #(
  parameter int SAMPLE_W   = 16,
  parameter int PWM_BITS   = 8,
  parameter int DIV        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SIGNED_IN  = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [SAMPLE_W-1:0]           din_i,
  input  logic                          din_valid_i,
  output logic                          din_ready_o,
  input  logic                          mode_i,
  input  logic                          enable_i,
  output logic                          amp_pwm_o,
  output logic                          amp_sd_o,
  output logic                          done_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(1) << (PWM_BITS - 1);
  logic [PWM_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PWM_BITS-1:0] pcnt_q, pcnt_d, acc_q, acc_d, cur_q, cur_d;
  logic                mode_q, mode_d, pwm_q, pwm_d, sd_q, done_q, und_q, und_d;
  logic [SAMPLE_W-1:0] din_u;
  logic [PWM_BITS-1:0] din_duty;
  logic [PWM_BITS:0]   sum;
  logic                push, pop, tick, bnd, full, empty;
  logic                unused_lsbs;
  // Only the duty survives into the FIFO, so the offset-binary conversion happens on entry.
  assign din_u       = din_i ^ {(SIGNED_IN != 0), {(SAMPLE_W-1){1'b0}}};
  assign din_duty    = din_u[SAMPLE_W-1 -: PWM_BITS];
  assign unused_lsbs = ^din_u;
  assign full        = lvl_q == LW'(FIFO_DEPTH);
  assign empty       = lvl_q == '0;
  assign din_ready_o = !full;
  assign push        = din_valid_i && !full;
  assign tick        = enable_i && cnt_q == CW'(DIV - 1);
  assign bnd         = tick && &pcnt_q;
  // Pop uses the registered level, so a push landing on a boundary plays one period later.
  assign pop         = bnd && !empty;
  always_comb begin
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    lvl_d  = lvl_q + LW'(push) - LW'(pop);
    cnt_d  = !enable_i || tick ? '0 : cnt_q + 1'b1;
    pcnt_d = !enable_i ? '0 : pcnt_q + PWM_BITS'(tick);
    cur_d  = pop ? mem_q[rd_q] : bnd ? MID : cur_q;
    mode_d = bnd ? mode_i : mode_q;
    // The boundary tick already belongs to the new period, so it uses the new duty and mode.
    sum    = {1'b0, acc_q} + {1'b0, cur_d};
    acc_d  = !enable_i ? '0 : tick && mode_d ? sum[PWM_BITS-1:0] : acc_q;
    pwm_d  = !enable_i ? 1'b0 : !tick ? pwm_q : mode_d ? sum[PWM_BITS] : pcnt_d < cur_d;
    und_d  = !enable_i ? 1'b0 : (bnd && empty) || und_q;
  end
  always_ff @(posedge clk_i)
    if (push) mem_q[wr_q] <= din_duty;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      cnt_q  <= '0;
      pcnt_q <= '0;
      acc_q  <= '0;
      cur_q  <= MID;
      mode_q <= 1'b0;
      pwm_q  <= 1'b0;
      sd_q   <= 1'b0;
      done_q <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      acc_q  <= acc_d;
      cur_q  <= cur_d;
      mode_q <= mode_d;
      pwm_q  <= pwm_d;
      sd_q   <= enable_i;
      done_q <= pop;
      und_q  <= und_d;
    end
  end
  assign amp_pwm_o    = pwm_q;
  assign amp_sd_o     = sd_q;
  assign done_o       = done_q;
  assign underrun_o   = und_q;
  assign fifo_level_o = lvl_q;
endmodule

// File: tb/tb_pcm_pwm_out.sv
// tb_pcm_pwm_out: scoreboard bench; each accepted sample queues its expected period, checked on done.
module tb_pcm_pwm_out;
  logic        clk = 1'b0;
  logic        reset, din_valid, din_ready, mode, enable, amp_pwm, amp_sd, done, underrun;
  logic [15:0] din;
  logic [2:0]  level;
  typedef struct {
    int ones;
    bit pdm;
  } exp_t;
  exp_t   exp_q[$];
  int     compared = 0;
  int     mismatched = 0;
  longint cyc = 0;
  pcm_pwm_out #(.SAMPLE_W(16), .PWM_BITS(8), .DIV(1), .FIFO_DEPTH(4), .SIGNED_IN(1)) dut (
    .clk_i(clk), .reset_i(reset), .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready),
    .mode_i(mode), .enable_i(enable), .amp_pwm_o(amp_pwm), .amp_sd_o(amp_sd), .done_o(done),
    .underrun_o(underrun), .fifo_level_o(level)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push(input logic [15:0] v);
    din = v;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, seen, 1);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (done && !reset) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          int ones, bad, gap_bad, last;
          e = exp_q.pop_front();
          ones = 0; bad = 0; gap_bad = 0; last = -1;
          for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            ones += int'(amp_pwm);
            if (!e.pdm && amp_pwm != (i < e.ones)) bad++;
            if (e.pdm && amp_pwm) begin
              if (last >= 0 && i - last != 4) gap_bad++;
              last = i;
            end
          end
          chk($sformatf("period_ones_%0d", e.ones), ones, e.ones);
          if (!e.pdm) chk($sformatf("pwm_shape_%0d", e.ones), bad, 0);
          else chk($sformatf("pdm_spacing_%0d", e.ones), gap_bad, 0);
        end
      end
    end
  end
  initial begin
    longint t;
    int ones;
    bit seen;
    reset = 1'b1; enable = 1'b0; mode = 1'b0; din = '0; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_amp_pwm", amp_pwm, 0);
    chk("rst_amp_sd", amp_sd, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", din_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    push(16'h4000); exp_q.push_back('{192, 1'b0});
    push(16'hC000); exp_q.push_back('{64, 1'b1});
    chk("preload_level", level, 2);
    enable = 1'b1;
    @(negedge clk);
    chk("amp_sd_on", amp_sd, 1);
    wait_done("p1_4000");
    repeat (100) @(negedge clk);
    mode = 1'b1;
    wait_done("p2_c000");
    repeat (100) @(negedge clk);
    mode = 1'b0;
    push(16'h8000); exp_q.push_back('{0, 1'b0});
    push(16'h7FFF); exp_q.push_back('{255, 1'b0});
    wait_done("p3_8000");
    t = cyc;
    wait_done("p4_7fff");
    chk("done_spacing", cyc - t, 256);
    seen = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (underrun) begin
        seen = 1'b1;
        break;
      end
    end
    chk("underrun_set", seen, 1);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      ones += int'(amp_pwm);
    end
    chk("silence_ones", ones, 128);
    @(negedge clk);
    chk("underrun_sticky", underrun, 1);
    chk("no_done_on_empty", done, 0);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_clears_underrun", underrun, 0);
    chk("disable_amp_sd", amp_sd, 0);
    chk("disable_amp_pwm", amp_pwm, 0);
    chk("ready_p1", din_ready, 1);
    push(16'h0000); exp_q.push_back('{128, 1'b0});
    chk("ready_p2", din_ready, 1);
    push(16'h1234); exp_q.push_back('{146, 1'b0});
    chk("ready_p3", din_ready, 1);
    push(16'hF000); exp_q.push_back('{112, 1'b0});
    chk("ready_p4", din_ready, 1);
    push(16'h7F00); exp_q.push_back('{255, 1'b0});
    chk("full_level", level, 4);
    chk("full_ready", din_ready, 0);
    push(16'h8000);
    chk("full_drop_level", level, 4);
    chk("idle_amp_sd", amp_sd, 0);
    chk("idle_amp_pwm", amp_pwm, 0);
    enable = 1'b1;
    wait_done("q1");
    wait_done("q2");
    wait_done("q3");
    wait_done("q4");
    repeat (300) @(negedge clk);
    chk("mid_underrun", underrun, 1);
    chk("mid_amp_pwm_high", amp_pwm, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_amp_pwm", amp_pwm, 0);
    chk("midrst_amp_sd", amp_sd, 0);
    chk("midrst_done", done, 0);
    chk("midrst_underrun", underrun, 0);
    chk("midrst_level", level, 0);
    chk("midrst_ready", din_ready, 1);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
